// File: rtl/scanline_fetcher.sv
// Double-buffered scanline fetcher: streams one image line from SRAM into a fill bank
// while the other bank feeds the display pixel by pixel.
module scanline_fetcher #(
    parameter int unsigned WIDTH  = 226,
    parameter int unsigned LINES  = 240,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    output logic              req_start_n,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_rw,
    input  logic              ready,
    input  logic [15:0]       rd_data,
    input  logic [9:0]        pix_x,
    output logic [15:0]       pix_data,
    output logic              fetch_busy,
    output logic              overrun
);

    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DATA_W = 16;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_nxt;
    logic              bank_sel;
    logic              bank_sel_nxt;
    logic [1:0]        valid;
    logic [1:0]        valid_nxt;
    logic              overrun_nxt;
    logic              fetch_busy_nxt;
    logic [ADDR_W-1:0] req_addr_nxt;
    logic              wr_en;
    logic              disp_sel;
    logic              pix_in_range;

    // bank_sel names the fill bank; the other one is on display
    logic [DATA_W-1:0] bank_mem [2][WIDTH];

    assign req_rw       = 1'b1;
    assign disp_sel     = ~bank_sel;
    assign pix_in_range = (32'(pix_x) < WIDTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // line_start outranks ready: a same-cycle ready word is dropped with the aborted fetch
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        base_nxt     = base;
        bank_sel_nxt = bank_sel;
        valid_nxt    = valid;
        overrun_nxt  = overrun;
        wr_en        = 1'b0;

        if (line_start) begin
            bank_sel_nxt          = ~bank_sel;
            valid_nxt[~bank_sel]  = 1'b0;
            if (state == FETCH) begin
                overrun_nxt = 1'b1;
            end
            if (32'(line_y) < LINES) begin
                base_nxt  = ADDR_W'(line_y) * ADDR_W'(WIDTH);
                idx_nxt   = '0;
                state_nxt = FETCH;
            end else begin
                state_nxt = IDLE;
            end
        end else if ((state == FETCH) && ready) begin
            wr_en = 1'b1;
            if (idx == IDX_LAST) begin
                valid_nxt[bank_sel] = 1'b1;
                state_nxt           = IDLE;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end

        fetch_busy_nxt = (state_nxt == FETCH);
        req_addr_nxt   = base_nxt + ADDR_W'(idx_nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            base        <= '0;
            bank_sel    <= 1'b0;
            valid       <= 2'b00;
            overrun     <= 1'b0;
            fetch_busy  <= 1'b0;
            req_start_n <= 1'b1;
            req_addr    <= '0;
        end else begin
            idx         <= idx_nxt;
            base        <= base_nxt;
            bank_sel    <= bank_sel_nxt;
            valid       <= valid_nxt;
            overrun     <= overrun_nxt;
            fetch_busy  <= fetch_busy_nxt;
            req_start_n <= ~fetch_busy_nxt;
            req_addr    <= req_addr_nxt;
        end
    end

    // Line storage is never reset; the valid flags gate what reaches the display
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[bank_sel][idx] <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_data <= '0;
        end else if (pix_in_range && valid[disp_sel]) begin
            pix_data <= bank_mem[disp_sel][pix_x[IDX_W-1:0]];
        end else begin
            pix_data <= '0;
        end
    end

endmodule

// File: tb/tb_scanline_fetcher.sv
// Randomized bench for scanline_fetcher: SRAM controller model, line-level reference
// model feeding scoreboard queues, and an independent monitor that drains them.
module tb_scanline_fetcher;

    localparam int unsigned WIDTH  = 226;
    localparam int unsigned LINES  = 240;
    localparam int unsigned ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              line_start = 1'b0;
    logic [9:0]        line_y = '0;
    logic              req_start_n;
    logic [ADDR_W-1:0] req_addr;
    logic              req_rw;
    logic              ready = 1'b0;
    logic [15:0]       rd_data = '0;
    logic [9:0]        pix_x = '0;
    logic [15:0]       pix_data;
    logic              fetch_busy;
    logic              overrun;

    scanline_fetcher #(.WIDTH(WIDTH), .LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_y(line_y),
        .req_start_n(req_start_n), .req_addr(req_addr), .req_rw(req_rw),
        .ready(ready), .rd_data(rd_data), .pix_x(pix_x), .pix_data(pix_data),
        .fetch_busy(fetch_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // SRAM contents as a pure function of word address
    function automatic logic [15:0] sram_word(input int unsigned a);
        return 16'((a * 32'd40503) ^ (a >> 5) ^ 32'h0000A5C3);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- SRAM controller model ----------------
    int gap_cnt = 0;
    bit rand_gap = 1'b0;
    bit junk_ready = 1'b0;
    int ready_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            ready   = 1'b0;
            gap_cnt = 0;
        end else if (req_start_n == 1'b0) begin
            if (gap_cnt == 0) begin
                ready   = 1'b1;
                rd_data = sram_word(32'(req_addr));
                ready_cnt++;
                gap_cnt = rand_gap ? int'($urandom_range(0, 3)) : 3;
            end else begin
                ready = 1'b0;
                gap_cnt--;
            end
        end else if (junk_ready) begin
            ready   = 1'($urandom_range(0, 1));
            rd_data = 16'($urandom);
        end else begin
            ready = 1'b0;
        end
    end

    // ---------------- pixel sweep ----------------
    int p = 0;
    always @(posedge clk) begin
        #2;
        if (p <= 230)      pix_x = 10'(p);
        else if (p == 231) pix_x = 10'd639;
        else               pix_x = 10'd1023;
        p = (p == 232) ? 0 : p + 1;
    end

    // ---------------- reference model (line-level) ----------------
    logic [ADDR_W-1:0] addr_q[$];
    logic [15:0]       pix_q[$];
    bit m_fetch = 0, m_fill_done = 0, m_disp_valid = 0, m_overrun = 0;
    int m_fill_y = 0, m_disp_y = 0, m_cnt = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_fetch = 0; m_fill_done = 0; m_disp_valid = 0; m_overrun = 0;
            m_cnt = 0;
            addr_q.delete();
            pix_q.delete();
        end else begin
            if ((32'(pix_x) < WIDTH) && m_disp_valid)
                pix_q.push_back(sram_word(32'(m_disp_y) * WIDTH + 32'(pix_x)));
            else
                pix_q.push_back(16'h0000);

            if (line_start) begin
                if (m_fetch) m_overrun = 1;
                m_disp_valid = m_fill_done;
                m_disp_y     = m_fill_y;
                m_fill_done  = 0;
                addr_q.delete();
                if (32'(line_y) < LINES) begin
                    m_fetch  = 1;
                    m_fill_y = int'(line_y);
                    m_cnt    = 0;
                    for (int i = 0; i < int'(WIDTH); i++)
                        addr_q.push_back(ADDR_W'(int'(line_y) * int'(WIDTH) + i));
                end else begin
                    m_fetch = 0;
                end
            end else if (ready && m_fetch) begin
                m_cnt++;
                if (m_cnt == int'(WIDTH)) begin
                    m_fetch     = 0;
                    m_fill_done = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (ready && !req_start_n) begin
                if (addr_q.size() == 0) begin
                    check("req_beyond_line", 32'(req_addr), 32'hFFFFFFFF);
                end else begin
                    check("req_addr", 32'(req_addr), 32'(addr_q.pop_front()));
                end
            end
            check("req_start_n", 32'(req_start_n), 32'(!m_fetch));
            check("fetch_busy", 32'(fetch_busy), 32'(m_fetch));
            check("overrun", 32'(overrun), 32'(m_overrun));
            check("req_rw", 32'(req_rw), 32'd1);
            if (pix_q.size() != 0)
                check("pix_data", 32'(pix_data), 32'(pix_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_line(input int y);
        line_y     = 10'(y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!fetch_busy) done = 1;
            else tick();
        end
        check("fetch_done_in_time", 32'(done), 32'd1);
    endtask

    task automatic wait_pulses(input int n);
        int c0 = ready_cnt;
        bit done = 0;
        for (int i = 0; i < 4 * n + 20 && !done; i++) begin
            if (ready_cnt - c0 >= n) done = 1;
            else tick();
        end
        check("pulses_in_time", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_start_n"}, 32'(req_start_n), 32'd1);
        check({tag, "_req_addr"}, 32'(req_addr), 32'd0);
        check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        check({tag, "_fetch_busy"}, 32'(fetch_busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_req_rw"}, 32'(req_rw), 32'd1);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // line 3 at a steady 1-in-4 ready rate, then display it
        rand_gap = 0;
        start_line(3);
        check("first_addr_y3", 32'(req_addr), 32'd678);
        wait_idle(1200);
        start_line(10);
        repeat (240) tick();
        wait_idle(1200);

        // abort line 0 after 100 words
        start_line(0);
        wait_pulses(100);
        start_line(5);
        check("overrun_after_abort", 32'(overrun), 32'd1);
        check("restart_addr_y5", 32'(req_addr), 32'd1130);
        repeat (250) tick();
        wait_idle(1200);

        // off-image lines: no requests, blank display, idle ready ignored
        start_line(11);
        wait_idle(1200);
        start_line(240);
        check("no_req_y240", 32'(req_start_n), 32'd1);
        junk_ready = 1;
        repeat (250) tick();
        junk_ready = 0;
        start_line(600);
        repeat (250) tick();
        start_line(239);
        check("first_addr_y239", 32'(req_addr), 32'd54014);
        wait_idle(1200);
        start_line(2);
        repeat (240) tick();
        wait_idle(1200);

        // line_start coinciding with ready
        start_line(20);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (ready) seen = 1;
            end
            check("ready_seen", 32'(seen), 32'd1);
        end
        start_line(21);
        check("collide_addr_y21", 32'(req_addr), 32'd4746);
        wait_idle(1200);
        start_line(22);
        repeat (240) tick();
        wait_idle(1200);

        // random line starts at random times with random ready gaps
        rand_gap = 1;
        repeat (12) begin
            start_line(int'($urandom_range(0, 259)));
            repeat ($urandom_range(0, 1100)) tick();
        end
        wait_idle(1200);

        // asynchronous reset in the middle of a fetch
        rand_gap = 0;
        start_line(9);
        wait_pulses(50);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("midfetch");
        tick();
        reset_n = 1'b1;
        tick();
        start_line(4);
        repeat (240) tick();
        wait_idle(1200);
        start_line(6);
        repeat (240) tick();
        wait_idle(1200);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scanline_fetcher.md
SCANLINE_FETCHER -- requirements
Module: scanline_fetcher

Interface
REQ-001 Parameter WIDTH, default 226, pixels per stored image line.
REQ-002 Parameter LINES, default 240, valid image lines; a line_y at or above LINES is outside the image.
REQ-003 Parameter ADDR_W, default 20, SRAM word address width.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port line_start, input, 1: one-cycle pulse that requests a fetch of line line_y.
REQ-007 Port line_y, input, 10: line number to fetch, sampled only when line_start=1.
REQ-008 Port req_start_n, output, 1: active-low read request to the SRAM controller.
REQ-009 Port req_addr, output, ADDR_W: SRAM word address of the current request.
REQ-010 Port req_rw, output, 1: access direction; constant 1 (read).
REQ-011 Port ready, input, 1: one-cycle pulse from the controller; rd_data is valid in the same cycle.
REQ-012 Port rd_data, input, 16: read data (colour index).
REQ-013 Port pix_x, input, 10: display column being drawn.
REQ-014 Port pix_data, output, 16: colour index for pix_x from the display bank.
REQ-015 Port fetch_busy, output, 1: high while in FETCH.
REQ-016 Port overrun, output, 1: sticky flag; set when a fetch is aborted or skipped.

Function
REQ-017 The block SHALL hold two WIDTH x 16 line banks: a display bank and a fill bank, selected by bank_sel.
REQ-018 States: IDLE and FETCH.
- On line_start in any state, the block SHALL swap bank roles in the same cycle.
REQ-019 On line_start with line_y < LINES:
- base <= line_y * WIDTH, computed at ADDR_W bits with no truncation for line_y < LINES;
- idx <= 0;
- go to FETCH.
REQ-020 On line_start with line_y >= LINES: go to IDLE, and the fill bank SHALL be cleared to zero lazily.
- Clearing means a valid flag per bank is cleared.
- While its bank's valid flag is 0, pix_data SHALL read 0.
REQ-021 In FETCH, req_start_n=0 and req_addr=base+idx.
REQ-022 When ready=1 in FETCH:
- write rd_data to fill[idx];
- if idx==WIDTH-1: set the fill bank valid flag, go to IDLE, drive req_start_n=1 from the next cycle;
- otherwise idx <= idx+1, and req_addr SHALL advance in the next cycle.
REQ-023 ready=1 in IDLE SHALL be ignored (no write, no state change).
REQ-024 line_start arriving in FETCH SHALL:
- abort the current fetch;
- set overrun=1;
- leave the aborted bank's valid flag 0;
- then proceed per REQ-019/REQ-020.
REQ-025 line_start and ready in the same cycle: line_start wins; the ready data SHALL be discarded.
REQ-026 pix_data SHALL be registered, with 1-cycle latency from pix_x.
- pix_x >= WIDTH, or display bank invalid, SHALL give pix_data=0.
REQ-027 fetch_busy SHALL equal (state==FETCH).
REQ-028 req_rw SHALL be 1 at all times, including during reset.
REQ-029 A full line fetch SHALL occupy exactly WIDTH ready pulses.
- No request is issued beyond idx=WIDTH-1, and no address outside base..base+WIDTH-1 is driven while req_start_n=0.

Reset
REQ-030 While reset_n=0, the block SHALL force immediately:
- state=IDLE, idx=0, base=0, bank_sel=0, both valid flags=0;
- req_start_n=1, req_addr=0, pix_data=0, fetch_busy=0, overrun=0.
REQ-031 Reset asserted mid-FETCH SHALL abandon the fetch without completing it.
- req_start_n SHALL go high asynchronously.
REQ-032 Only reset clears overrun.
REQ-033 Bank contents need not be reset; the valid flags alone gate the output.

Verification
REQ-034 line_start with line_y=3, controller model giving ready every 4 cycles:
- req_addr steps 678..903;
- fetch_busy drops after 226 pulses;
- next line_start makes pixels visible;
- pix_x=0 -> word@678 one cycle later.
REQ-035 line_start with line_y=0, then a second line_start after 100 ready pulses:
- overrun=1;
- displayed bank reads 0 for all pix_x;
- new fetch restarts at idx 0.
REQ-036 line_y=240 -> no request issued (req_start_n stays 1); after the next swap, pix_data=0 for all pix_x.
REQ-037 line_start and ready in the same cycle -> the data is not written; fetch starts at the new base, idx 0.
REQ-038 reset_n low during FETCH at idx 50:
- req_start_n=1 and all outputs at reset values without waiting for a clk edge;
- after release, pix_data=0 until a full fetch and swap.
REQ-039 pix_x=225 -> last word; pix_x=226 and pix_x=639 -> 0.
